// File: rtl/csa_div_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : csa_div_pkg
//  Purpose  : Shared types and width helpers for the sequential CSA divider.
//  Revision : 1.0  initial release
// ============================================================================
package csa_div_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);
  localparam int SIGN_IDX      = DEFAULT_WIDTH;

  // Divider sequencing states, fixed 2-bit encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter width able to hold the value w (iterations run 0..w-1, then wrap check)
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa_div_seq_row.sv
`default_nettype none
// ============================================================================
//  Module   : csa_row
//  Purpose  : One row of controlled subtract/add cells. ctrl=1 computes a-b,
//             ctrl=0 computes a+b, both modulo 2^N (b is XORed by ctrl and
//             ctrl is the carry-in of the ripple chain).
//  Revision : 1.0  initial release
// ============================================================================
module csa_row #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ctrl,
  output logic [N-1:0] o
);

  // carry[i] is the carry into cell i; carry out of the MSB cell is discarded
  logic [N-1:0] carry;
  logic [N-1:0] bx;

  assign carry[0] = ctrl;
  assign bx       = b ^ {N{ctrl}};

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign o[i] = a[i] ^ bx[i] ^ carry[i];
    if (i < N - 1) begin : g_carry
      assign carry[i+1] = (a[i] & bx[i]) | (a[i] & carry[i]) | (bx[i] & carry[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/csa_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : csa_div_seq
//  Purpose  : Sequential unsigned non-restoring divider. One csa_row is reused
//             for WIDTH iterations, then once more for remainder correction.
//             Valid/ready request and response ports.
//  Revision : 1.0  initial release
// ============================================================================
module csa_div_seq
  import csa_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_BITS = cnt_width(WIDTH);
  localparam int SGN      = WIDTH;

  state_t              state;
  logic [WIDTH:0]      p_reg;   // signed partial remainder
  logic [WIDTH-1:0]    a_reg;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]    b_reg;   // divisor
  logic [CNT_BITS-1:0] cnt;

  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] row_a;
  logic [WIDTH:0] row_b;
  logic [WIDTH:0] row_o;
  logic           row_ctrl;

  // Iteration operand: {P,A} shifted left by one; add/sub chosen by pre-shift sign.
  // In FIX the row only ever adds B back to the unshifted P.
  assign p_shift  = {p_reg[WIDTH-1:0], a_reg[WIDTH-1]};
  assign row_ctrl = (state == CALC) ? ~p_reg[SGN] : 1'b0;
  assign row_a    = (state == CALC) ? p_shift : p_reg;
  assign row_b    = {1'b0, b_reg};

  csa_row #(.N(WIDTH + 1)) u_row (
    .a    (row_a),
    .b    (row_b),
    .ctrl (row_ctrl),
    .o    (row_o)
  );

  // FSM, datapath registers and registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      p_reg       <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              p_reg <= '0;
              a_reg <= dividend;
              b_reg <= divisor;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          p_reg <= row_o;
          a_reg <= {a_reg[WIDTH-2:0], ~row_o[SGN]};
          cnt   <= cnt + CNT_BITS'(1);
          if (cnt == CNT_BITS'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Negative partial remainder gets B added back once
          if (p_reg[SGN]) begin
            p_reg <= row_o;
          end
          quotient    <= a_reg;
          remainder   <= p_reg[SGN] ? row_o[WIDTH-1:0] : p_reg[WIDTH-1:0];
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csa_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_div_seq
//  Purpose  : Scoreboard bench for csa_div_seq. The driver pushes expected
//             results on each accepted request; a monitor pops and compares
//             whenever out_valid is presented.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csa_div_seq;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           acc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sbq[$];

  csa_div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Issue one request; expected values are pushed before the accepting edge
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
    exp_t e;
    int   t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      timeout("wait_in_ready");
      return;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) do_op(a, b, '1, a, 1'b1);
    else         do_op(a, b, a / b, a % b, 1'b0);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || !in_ready) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (sbq.size() != 0 || !in_ready) timeout("drain");
  endtask

  // Monitor: compare first presentation of each result; hold-stability while stalled
  initial begin : monitor
    exp_t         e;
    logic         seen;
    logic [W-1:0] cap_q;
    logic [W-1:0] cap_r;
    logic         cap_z;
    seen = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst || !out_valid) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen  = 1'b1;
        cap_q = quotient;
        cap_r = remainder;
        cap_z = div_by_zero;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got q=%0d r=%0d with empty scoreboard", quotient, remainder);
        end else begin
          e = sbq.pop_front();
          check("quotient", 32'(quotient), 32'(e.q));
          check("remainder", 32'(remainder), 32'(e.r));
          check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
          // latency counts the accepting edge as cycle 1
          check("latency", 32'(cyc - e.acc + 1), e.dbz ? 32'd1 : 32'(W + 2));
        end
      end else begin
        check("hold_quotient", 32'(quotient), 32'(cap_q));
        check("hold_remainder", 32'(remainder), 32'(cap_r));
        check("hold_dbz", 32'(div_by_zero), 32'(cap_z));
        check("stall_in_ready", 32'(in_ready), 32'd0);
      end
    end
  end

  vec_t vecs[13] = '{
    '{16'd100,   16'd7,     16'd14,    16'd2,    1'b0},
    '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0,    1'b0},
    '{16'd5,     16'd9,     16'd0,     16'd5,    1'b0},
    '{16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1},
    '{16'd9,     16'd3,     16'd3,     16'd0,    1'b0},
    '{16'd0,     16'd5,     16'd0,     16'd0,    1'b0},
    '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,    1'b0},
    '{16'd65535, 16'd256,   16'd255,   16'd255,  1'b0},
    '{16'd12345, 16'd123,   16'd100,   16'd45,   1'b0},
    '{16'd1,     16'd65535, 16'd0,     16'd1,    1'b0},
    '{16'd0,     16'd0,     16'hFFFF,  16'd0,    1'b1},
    '{16'd32768, 16'd2,     16'd16384, 16'd0,    1'b0},
    '{16'd40000, 16'd40001, 16'd0,     16'd40000,1'b0}
  };

  initial begin : stimulus
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
      if (vecs[i].b != '0) begin
        check("busy_in_calc", 32'(busy), 32'd1);
        check("in_ready_in_calc", 32'(in_ready), 32'd0);
      end
    end
    wait_drain();

    // Backpressure: 1000/3 held for 10 stalled cycles
    out_ready = 1'b0;
    do_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
    begin : wait_valid
      int t;
      t = 0;
      while (!out_valid && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      if (!out_valid) timeout("bp_out_valid");
    end
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // in_valid pulses while busy must be ignored
    do_op(16'd200, 16'd7, 16'd28, 16'd4, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    dividend = 16'd1;
    divisor  = 16'd1;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("busy_ignore_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_drain();

    // Reset during CALC at cnt=5 aborts the operation
    do_op(16'd500, 16'd3, 16'd166, 16'd2, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sbq.delete();
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    do_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0);
    wait_drain();

    // Mixed pairs against a / and % model: divisor 1, divisor > dividend, general
    for (int i = 0; i < 120; i++) begin
      case (i % 4)
        0: begin a = W'($urandom);            b = 16'd1; end
        1: begin a = W'($urandom);            b = W'($urandom); end
        2: begin a = W'($urandom);            b = W'($urandom_range(1, 255)); end
        default: begin a = W'($urandom_range(0, 999)); b = W'($urandom_range(1000, 65535)); end
      endcase
      do_model(a, b);
    end
    wait_drain();
    check("final_out_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
